// File: rtl/ysyx_branch_unit.sv
// ysyx_branch_unit: execute-stage branch resolution with a one-entry registered
// result stage, redirect generation, misprediction detection, a PC-indexed
// table of 2-bit saturating counters for fetch-time prediction, and
// resolved-branch / misprediction counters.
module ysyx_branch_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,

    // Fetch-side prediction port
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,

    // Execute-side request
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [2:0]       in_type,
    input  logic             in_pred_taken,
    input  logic             flush,

    // Registered result
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic             out_mispredict,
    output logic [XLEN-1:0]  out_redirect_pc,

    // Performance counters
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int unsigned IDX = $clog2(BHT_ENTRIES);

    localparam logic [2:0] TYPE_EQ  = 3'b010;
    localparam logic [2:0] TYPE_NE  = 3'b011;
    localparam logic [2:0] TYPE_LT  = 3'b100;
    localparam logic [2:0] TYPE_GE  = 3'b101;
    localparam logic [2:0] TYPE_LTU = 3'b110;
    localparam logic [2:0] TYPE_GEU = 3'b111;

    localparam logic [1:0] CNT_RESET = 2'b01;

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } state_t;

    state_t state_q, state_d;

    // Handshake signals
    logic acc;
    logic out_hs;

    // Combinational resolution of the incoming request
    logic            is_branch;
    logic            cmp_taken;
    logic [XLEN-1:0] target_d;
    logic [XLEN-1:0] fall_through;
    logic [XLEN-1:0] redirect_d;
    logic            mispredict_d;

    // Result register
    logic            taken_q;
    logic [XLEN-1:0] target_q;
    logic            mispredict_q;
    logic [XLEN-1:0] redirect_q;
    logic            is_branch_q;

    // Prediction table
    logic [1:0]     bht_q [BHT_ENTRIES];
    logic [IDX-1:0] upd_idx;
    logic [IDX-1:0] rd_idx;
    logic [1:0]     upd_cnt;
    logic [1:0]     upd_cnt_next;

    // Performance counters
    logic [CNT_W-1:0] stat_branches_q;
    logic [CNT_W-1:0] stat_mispredicts_q;

    // Bits of pred_pc that do not participate in the table index
    logic unused_pred_pc_bits;
    assign unused_pred_pc_bits = ^{pred_pc[XLEN-1:IDX+2], pred_pc[1:0]};

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign out_valid = (state_q == StFull);
    assign in_ready  = ~out_valid | out_ready;
    assign acc       = in_valid & in_ready & ~flush;
    assign out_hs    = out_valid & out_ready & ~flush;

    // ------------------------------------------------------------------
    // Branch resolution
    // ------------------------------------------------------------------
    // Types 000/001 are not branches; every type with a nonzero upper pair is.
    assign is_branch = (in_type[2:1] != 2'b00);

    // Compare operands according to the branch type
    always_comb begin
        cmp_taken = 1'b0;
        case (in_type)
            TYPE_EQ:  cmp_taken = (in_src1 == in_src2);
            TYPE_NE:  cmp_taken = (in_src1 != in_src2);
            TYPE_LT:  cmp_taken = ($signed(in_src1) <  $signed(in_src2));
            TYPE_GE:  cmp_taken = ($signed(in_src1) >= $signed(in_src2));
            TYPE_LTU: cmp_taken = (in_src1 <  in_src2);
            TYPE_GEU: cmp_taken = (in_src1 >= in_src2);
            default:  cmp_taken = 1'b0;
        endcase
    end

    // Both sums wrap modulo 2^XLEN
    assign target_d     = in_pc + in_imm;
    assign fall_through = in_pc + XLEN'(4);
    assign redirect_d   = cmp_taken ? target_d : fall_through;
    // A non-branch that fetch predicted taken also needs a redirect
    assign mispredict_d = cmp_taken ^ in_pred_taken;

    // ------------------------------------------------------------------
    // Output state machine
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush wins, then a new accept keeps/makes the stage full
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StEmpty;
        end else if (acc) begin
            state_d = StFull;
        end else if (out_ready) begin
            state_d = StEmpty;
        end
    end

    // Result register loads only on accept, so it holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_q      <= 1'b0;
            target_q     <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            is_branch_q  <= 1'b0;
        end else if (acc) begin
            taken_q      <= cmp_taken;
            target_q     <= target_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            is_branch_q  <= is_branch;
        end
    end

    assign out_taken       = taken_q;
    assign out_target      = target_q;
    assign out_mispredict  = mispredict_q;
    assign out_redirect_pc = redirect_q;

    // ------------------------------------------------------------------
    // Prediction table
    // ------------------------------------------------------------------
    assign upd_idx = in_pc[IDX+1:2];
    assign rd_idx  = pred_pc[IDX+1:2];
    assign upd_cnt = bht_q[upd_idx];

    // Read returns the stored value, so a same-cycle update is seen next cycle
    assign pred_taken = bht_q[rd_idx][1];

    // Saturating increment on taken, decrement on not-taken
    always_comb begin
        upd_cnt_next = upd_cnt;
        if (cmp_taken) begin
            if (upd_cnt != 2'b11) begin
                upd_cnt_next = upd_cnt + 2'b01;
            end
        end else begin
            if (upd_cnt != 2'b00) begin
                upd_cnt_next = upd_cnt - 2'b01;
            end
        end
    end

    // Table storage; all entries start weak-not-taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CNT_RESET;
            end
        end else if (acc && is_branch) begin
            bht_q[upd_idx] <= upd_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    // Count on output handshake; results killed by flush are not counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else if (out_hs) begin
            if (is_branch_q) begin
                stat_branches_q <= stat_branches_q + CNT_W'(1);
            end
            if (mispredict_q) begin
                stat_mispredicts_q <= stat_mispredicts_q + CNT_W'(1);
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_ysyx_branch_unit.sv
// Directed bench for ysyx_branch_unit: a vector table for the compare/target
// path followed by hand-written sequences for prediction, stall, flush and reset.
module tb_ysyx_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [31:0] in_imm;
    logic [2:0]  in_type;
    logic        in_pred_taken;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target;
    logic        out_mispredict;
    logic [31:0] out_redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int checks = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_mis = 0;

    ysyx_branch_unit #(
        .XLEN(32),
        .BHT_ENTRIES(16),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pred_pc(pred_pc),
        .pred_taken(pred_taken),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pc(in_pc),
        .in_src1(in_src1),
        .in_src2(in_src2),
        .in_imm(in_imm),
        .in_type(in_type),
        .in_pred_taken(in_pred_taken),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_taken(out_taken),
        .out_target(out_target),
        .out_mispredict(out_mispredict),
        .out_redirect_pc(out_redirect_pc),
        .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        pred;
        logic        e_taken;
        logic [31:0] e_target;
        logic        e_mis;
        logic [31:0] e_redir;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic [2:0] typ, input logic [31:0] pc,
                                input logic [31:0] imm, input logic [31:0] s1,
                                input logic [31:0] s2, input logic pred,
                                input logic e_taken, input logic [31:0] e_target,
                                input logic e_mis, input logic [31:0] e_redir);
        vec_t v;
        v.typ = typ; v.pc = pc; v.imm = imm; v.s1 = s1; v.s2 = s2; v.pred = pred;
        v.e_taken = e_taken; v.e_target = e_target; v.e_mis = e_mis; v.e_redir = e_redir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] typ, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] s1, input logic [31:0] s2, input logic pred);
        in_valid      = 1'b1;
        in_type       = typ;
        in_pc         = pc;
        in_imm        = imm;
        in_src1       = s1;
        in_src2       = s2;
        in_pred_taken = pred;
    endtask

    localparam logic [31:0] TRAIN_PC = 32'h8000_0010;

    initial begin
        logic exp_pred [3];
        exp_pred[0] = 1'b0;
        exp_pred[1] = 1'b1;
        exp_pred[2] = 1'b1;

        //             type    pc            imm           src1          src2         pred  tk   target        mis  redirect
        vecs[0] = mk(3'b100, 32'h0000_1000, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_1020, 1'b1, 32'h0000_1020);
        vecs[1] = mk(3'b110, 32'h0000_1000, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_1020, 1'b0, 32'h0000_1004);
        vecs[2] = mk(3'b111, 32'h0000_1000, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_1020, 1'b0, 32'h0000_1020);
        vecs[3] = mk(3'b101, 32'h0000_1000, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_1020, 1'b1, 32'h0000_1004);
        vecs[4] = mk(3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0055, 32'h0000_0055, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004);
        vecs[5] = mk(3'b011, 32'h0000_2000, 32'hFFFF_FFF0, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 32'h0000_1FF0, 1'b0, 32'h0000_2004);
        vecs[6] = mk(3'b000, 32'h0000_3000, 32'h0000_0100, 32'h0000_0009, 32'h0000_0009, 1'b1, 1'b0, 32'h0000_3100, 1'b1, 32'h0000_3004);
        vecs[7] = mk(3'b001, 32'h0000_3008, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_300C, 1'b0, 32'h0000_300C);
        vecs[8] = mk(3'b100, 32'h0000_4000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_4000, 1'b1, 32'h0000_4004);
        vecs[9] = mk(3'b110, 32'h0000_4000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 32'h0000_4000, 1'b0, 32'h0000_4000);

        // Reset state
        rst = 1'b1;
        pred_pc = TRAIN_PC;
        in_valid = 1'b1;
        in_pc = 32'h0; in_src1 = 32'h0; in_src2 = 32'h0; in_imm = 32'h0;
        in_type = 3'b010; in_pred_taken = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_out_target", out_target, 32'h0);
        chk("rst_redirect", out_redirect_pc, 32'h0);
        chk("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
        chk("rst_stat_br", stat_branches, 32'h0);
        chk("rst_stat_mis", stat_mispredicts, 32'h0);
        step();
        step();
        chk("rst_no_accept", {31'b0, out_valid}, 32'h0);
        rst = 1'b0;
        in_valid = 1'b0;
        step();

        // Vector table, back-to-back with the consumer always ready
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].typ, vecs[i].pc, vecs[i].imm, vecs[i].s1, vecs[i].s2, vecs[i].pred);
            step();
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'h1);
            chk($sformatf("vec%0d_taken", i), {31'b0, out_taken}, {31'b0, vecs[i].e_taken});
            chk($sformatf("vec%0d_target", i), out_target, vecs[i].e_target);
            chk($sformatf("vec%0d_mispredict", i), {31'b0, out_mispredict}, {31'b0, vecs[i].e_mis});
            chk($sformatf("vec%0d_redirect", i), out_redirect_pc, vecs[i].e_redir);
            if (vecs[i].typ[2:1] != 2'b00) exp_br++;
            if (vecs[i].e_mis) exp_mis++;
        end
        in_valid = 1'b0;
        step();
        chk("vec_drain_valid", {31'b0, out_valid}, 32'h0);
        chk("vec_stat_br", stat_branches, exp_br);
        chk("vec_stat_mis", stat_mispredicts, exp_mis);

        // Counter training and saturation at TRAIN_PC
        for (int k = 0; k < 3; k++) begin
            drive(3'b010, TRAIN_PC, 32'h0, 32'h0, 32'h0, 1'b0);
            chk($sformatf("sat_taken%0d_pred", k), {31'b0, pred_taken}, {31'b0, exp_pred[k]});
            step();
            exp_br++;
            exp_mis++;
        end
        chk("sat_strong_t", {31'b0, pred_taken}, 32'h1);
        drive(3'b011, TRAIN_PC, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        chk("sat_weak_t", {31'b0, pred_taken}, 32'h1);
        step();
        chk("sat_weak_nt", {31'b0, pred_taken}, 32'h0);
        step();
        exp_br += 3;
        // From 00 one taken lands on 01 (still not taken); from 01 it would flip
        drive(3'b010, TRAIN_PC, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        exp_br++;
        exp_mis++;
        chk("sat_strong_nt", {31'b0, pred_taken}, 32'h0);
        in_valid = 1'b0;
        step();
        chk("sat_stat_br", stat_branches, exp_br);
        chk("sat_stat_mis", stat_mispredicts, exp_mis);

        // Backpressure: result holds and input stalls while the consumer stalls
        out_ready = 1'b0;
        drive(3'b010, 32'h0000_0500, 32'h0000_0040, 32'h1, 32'h1, 1'b1);
        step();
        chk("bp_first_valid", {31'b0, out_valid}, 32'h1);
        drive(3'b101, 32'h0000_0600, 32'h0000_0010, 32'h3, 32'h7, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp%0d_in_ready", c), {31'b0, in_ready}, 32'h0);
            chk($sformatf("bp%0d_valid", c), {31'b0, out_valid}, 32'h1);
            chk($sformatf("bp%0d_target", c), out_target, 32'h0000_0540);
            chk($sformatf("bp%0d_redirect", c), out_redirect_pc, 32'h0000_0540);
            chk($sformatf("bp%0d_taken", c), {31'b0, out_taken}, 32'h1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'b0, in_ready}, 32'h1);
        step();
        chk("bp_next_valid", {31'b0, out_valid}, 32'h1);
        chk("bp_next_target", out_target, 32'h0000_0610);
        chk("bp_next_redirect", out_redirect_pc, 32'h0000_0604);
        chk("bp_next_mispredict", {31'b0, out_mispredict}, 32'h1);
        exp_br += 2;
        exp_mis += 1;
        in_valid = 1'b0;
        step();
        chk("bp_drain_valid", {31'b0, out_valid}, 32'h0);
        chk("bp_stat_br", stat_branches, exp_br);
        chk("bp_stat_mis", stat_mispredicts, exp_mis);

        // Flush with a valid output and a valid request in the same cycle
        drive(3'b010, 32'h0000_0700, 32'h0000_0010, 32'h2, 32'h2, 1'b0);
        step();
        chk("fl_pre_valid", {31'b0, out_valid}, 32'h1);
        drive(3'b010, TRAIN_PC, 32'h0, 32'h0, 32'h0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'b0, out_valid}, 32'h0);
        chk("fl_bht_unchanged", {31'b0, pred_taken}, 32'h0);
        chk("fl_stat_br", stat_branches, exp_br);
        chk("fl_stat_mis", stat_mispredicts, exp_mis);
        step();
        chk("fl_later_valid", {31'b0, out_valid}, 32'h0);
        chk("fl_later_stat_br", stat_branches, exp_br);

        // Train three taken branches, then pulse reset between edges
        for (int k = 0; k < 3; k++) begin
            drive(3'b010, TRAIN_PC, 32'h0000_0020, 32'h0, 32'h0, 1'b1);
            step();
        end
        in_valid = 1'b0;
        chk("ar_trained_pred", {31'b0, pred_taken}, 32'h1);
        chk("ar_pre_valid", {31'b0, out_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", {31'b0, out_valid}, 32'h0);
        chk("ar_stat_br", stat_branches, 32'h0);
        chk("ar_stat_mis", stat_mispredicts, 32'h0);
        chk("ar_pred", {31'b0, pred_taken}, 32'h0);
        chk("ar_target", out_target, 32'h0);
        chk("ar_taken", {31'b0, out_taken}, 32'h0);
        chk("ar_in_ready", {31'b0, in_ready}, 32'h1);
        drive(3'b010, TRAIN_PC, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        chk("ar_hold_valid", {31'b0, out_valid}, 32'h0);
        chk("ar_hold_pred", {31'b0, pred_taken}, 32'h0);
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        chk("ar_after_valid", {31'b0, out_valid}, 32'h0);
        chk("ar_after_stat_br", stat_branches, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_branch_unit.md
# ysyx_branch_unit

Parametrised branch resolution unit for the ysyx core's execute stage. It replaces the purely combinational branch comparator with several additions:
- a registered valid/ready output stage;
- branch target and redirect generation;
- misprediction detection;
- a PC-indexed table of 2-bit saturating counters that gives the fetch stage a taken/not-taken prediction.

Performance counters track resolved branches and mispredictions.

## Interface
Parameters:
- XLEN, 32, datapath and PC width (≥ 8).
- BHT_ENTRIES, 16, prediction table depth; power of two ≥ 2; IDX = log2(BHT_ENTRIES).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pred_pc  in  XLEN  fetch PC to predict for.
- pred_taken  out  1  combinational prediction for pred_pc.
- in_valid  in  1  execute-side request valid.
- in_ready  out  1  unit can accept a request.
- in_pc  in  XLEN  PC of the instruction.
- in_src1, in_src2  in  XLEN  operands.
- in_imm  in  XLEN  sign-extended branch offset.
- in_type  in  3  compare type:
  - 010 eq, 011 ne, 100 lt signed, 101 ge signed, 110 lt unsigned, 111 ge unsigned;
  - 000/001 mean not a branch.
- in_pred_taken  in  1  prediction that fetch used for this instruction.
- flush  in  1  kill the in-flight result and the same-cycle request.
- out_valid  out  1  result register valid.
- out_ready  in  1  consumer accepts the result.
- out_taken  out  1  resolved direction.
- out_target  out  XLEN  in_pc + in_imm.
- out_mispredict  out  1  redirect required.
- out_redirect_pc  out  XLEN  correct next PC.
- stat_branches  out  CNT_W  resolved branch count.
- stat_mispredicts  out  CNT_W  misprediction count.

## Operation
- Accept handshake: acc = in_valid & in_ready & ~flush.
- in_ready = ~out_valid | out_ready. The input is combinationally dependent on out_ready, so a full pipeline stalls only while the consumer stalls.
- Compare:
  - signed types use two's-complement XLEN-bit compare;
  - unsigned types use magnitude compare;
  - eq/ne compare bitwise.
- out_taken = compare result for branch types; 0 for 000/001.
- All addition is modulo 2^XLEN and wraps silently:
  - out_target = in_pc + in_imm;
  - fall-through = in_pc + 4.
- out_mispredict = out_taken XOR in_pred_taken. This applies to non-branch types too: a predicted-taken non-branch mispredicts.
- out_redirect_pc = out_taken ? out_target : fall-through.
- Prediction table, BHT_ENTRIES × 2-bit counters:
  - index = pc[IDX+1:2];
  - pred_taken = counter[index][1].
- Table update: on acc with a branch type, the counter at in_pc's index increments (taken) or decrements (not taken), saturating at 11/00. Non-branch types never update the table.
- Counter state encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Output state machine, EMPTY/FULL (out_valid):
  - EMPTY→FULL on acc;
  - FULL→EMPTY on out_ready without acc;
  - FULL→FULL on out_ready with acc (result register reloads);
  - any→EMPTY on flush.
- Performance counters:
  - stat_branches += 1 on output handshake (out_valid & out_ready & ~flush) of a branch type;
  - stat_mispredicts += 1 on output handshake with out_mispredict;
  - both wrap at 2^CNT_W.

## Timing
- Latency 1 cycle: a request accepted at edge N is visible on out_* after edge N; throughput 1/cycle.
- Prediction read is combinational. When the same cycle reads and updates the same index, pred_taken returns the pre-update value; the new value is visible the next cycle.
- Flush:
  - out_valid = 0 after the edge;
  - the same-cycle request is dropped, with no table update;
  - a result handshaking in the flush cycle is not counted.
- Result register holds stable while out_valid & ~out_ready.
- Reset values, asynchronous, applied immediately on rst assertion including mid-operation:
  - out_valid 0;
  - out_taken 0, out_mispredict 0, out_target 0, out_redirect_pc 0;
  - stat_* 0;
  - all table counters 01, so pred_taken 0.
- While rst is high, in_ready = 1 but nothing is accepted.

## Test plan
- Signed vs unsigned: src1=0xFFFFFFFF, src2=1:
  - type 100 → taken=1;
  - type 110 → taken=0;
  - type 111 → taken=1;
  - type 101 → taken=0.
- Target wrap: pc=0xFFFFFFFC, imm=8, type 010, src1=src2, pred 0 → out_target=0x00000004, taken=1, mispredict=1, redirect_pc=0x00000004, stat_mispredicts=1.
- Counter saturation at pc=0x80000010:
  - three taken branches → pred_taken 0,1,1 on the following cycles, counter 11;
  - one not-taken → counter 10, still predicts taken;
  - two more not-taken → 00.
- Backpressure: hold out_ready=0 with out_valid=1 → in_ready=0, outputs stable for 5 cycles; raise out_ready with in_valid=1 → new result next cycle, no bubble.
- Flush in the same cycle as a valid request and a valid output → out_valid=0 next cycle; BHT entry and stat_* unchanged.
- Async reset mid-stream (rst pulsed between edges after 3 trained branches) → out_valid=0 and stat_*=0 immediately; pred_taken=0 for the trained PC.
